// File: rtl/cart_mem.sv
// Cartridge memory subsystem: loads a ROM image from the download port and
// commits its size, byte count and checksum. It then serves mirrored CPU reads
// and an optional cartridge RAM.
//
// state  | meaning
// IDLE   | waiting for INIT_SEL; the committed image, if any, is served
// LOAD   | streaming image bytes into ROM and updating the accumulators
// COMMIT | one cycle that registers size, checksum, count and READY
module cart_mem #(
  parameter int AW       = 17,
  parameter int MIN_LOG2 = 13,
  parameter int RAM_AW   = 11
) (
  input  logic          CLK,
  input  logic          RESB,
  input  logic          INIT_SEL,
  input  logic [AW-1:0] INIT_ADDR,
  input  logic [7:0]    INIT_DATA,
  input  logic          INIT_VALID,
  output logic [4:0]    SIZE_LOG2,
  output logic [31:0]   CKSUM,
  output logic [AW:0]   BYTE_CNT,
  output logic          READY,
  input  logic [AW-1:0] A,
  input  logic          CSB,
  input  logic          RAM_CSB,
  input  logic          WRB,
  input  logic [7:0]    DI,
  output logic [7:0]    DB
);

  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          load_start;
  logic          load_wr;
  logic [31:0]   cksum_acc;
  logic [CW-1:0] cnt_acc;
  logic [AW-1:0] max_addr;
  logic [4:0]    addr_bits;
  logic [4:0]    size_nxt;
  logic [AW-1:0] rom_mask;
  logic [AW-1:0] rom_idx;
  logic          ram_sel;
  logic          ram_we;
  logic [7:0]    ram_rdata;
  logic [7:0]    rom [2**AW];

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (INIT_SEL)  state_nxt = S_LOAD;
      S_LOAD:   if (!INIT_SEL) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // The byte offered on the IDLE->LOAD edge is accepted along with the clear.
  assign load_start = (state == S_IDLE) && INIT_SEL;
  assign load_wr    = INIT_SEL && INIT_VALID && ((state == S_IDLE) || (state == S_LOAD));

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      cksum_acc <= '0;
      cnt_acc   <= '0;
      max_addr  <= '0;
    end else if (load_start) begin
      cksum_acc <= load_wr ? {24'b0, INIT_DATA} : 32'd0;
      cnt_acc   <= load_wr ? CW'(1) : '0;
      max_addr  <= load_wr ? INIT_ADDR : '0;
    end else if (load_wr) begin
      cksum_acc <= cksum_acc + {24'b0, INIT_DATA};
      cnt_acc   <= cnt_acc + CW'(1);
      if (INIT_ADDR > max_addr) max_addr <= INIT_ADDR;
    end
  end

  // clog2(max_addr+1) is the bit length of max_addr.
  always_comb begin
    addr_bits = '0;
    for (int i = 0; i < AW; i++) begin
      if (max_addr[i]) addr_bits = 5'(i + 1);
    end
    if (cnt_acc == '0)                 size_nxt = '0;
    else if (addr_bits < 5'(MIN_LOG2)) size_nxt = 5'(MIN_LOG2);
    else                               size_nxt = addr_bits;
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      SIZE_LOG2 <= '0;
      CKSUM     <= '0;
      BYTE_CNT  <= '0;
      READY     <= 1'b0;
    end else if (state == S_COMMIT) begin
      SIZE_LOG2 <= size_nxt;
      CKSUM     <= cksum_acc;
      BYTE_CNT  <= cnt_acc;
      READY     <= (cnt_acc != '0);
    end else if (load_start) begin
      READY     <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (load_wr) rom[INIT_ADDR] <= INIT_DATA;
  end

  assign rom_mask = AW'((64'd1 << SIZE_LOG2) - 64'd1);
  assign rom_idx  = A & rom_mask;
  assign ram_we   = ram_sel && CSB && READY && !WRB;

  if (RAM_AW > 0) begin : g_ram
    logic [7:0] ram [2**RAM_AW];

    assign ram_sel   = !RAM_CSB;
    assign ram_rdata = ram[A[RAM_AW-1:0]];

    always_ff @(posedge CLK) begin
      if (ram_we) ram[A[RAM_AW-1:0]] <= DI;
    end
  end else begin : g_no_ram
    assign ram_sel   = 1'b0;
    assign ram_rdata = 8'hFF;
  end

  // ROM wins when both selects are low; an unready image reads as 0xFF.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB)        DB <= 8'h00;
    else if (!CSB)    DB <= READY ? rom[rom_idx] : 8'hFF;
    else if (ram_sel) DB <= READY ? ram_rdata : 8'hFF;
  end

endmodule

// File: tb/tb_cart_mem.sv
// Scoreboard bench for cart_mem: loads images, checks committed results,
// mirrored ROM reads, cartridge RAM behaviour and asynchronous reset.
module tb_cart_mem;

  localparam int AW = 17;

  logic          CLK = 1'b0;
  logic          RESB;
  logic          INIT_SEL;
  logic [AW-1:0] INIT_ADDR;
  logic [7:0]    INIT_DATA;
  logic          INIT_VALID;
  logic [4:0]    SIZE_LOG2;
  logic [31:0]   CKSUM;
  logic [AW:0]   BYTE_CNT;
  logic          READY;
  logic [AW-1:0] A;
  logic          CSB;
  logic          RAM_CSB;
  logic          WRB;
  logic [7:0]    DI;
  logic [7:0]    DB;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [7:0]  mdl [2**AW];

  cart_mem #(.AW(AW), .MIN_LOG2(13), .RAM_AW(11)) dut (
    .CLK(CLK), .RESB(RESB), .INIT_SEL(INIT_SEL), .INIT_ADDR(INIT_ADDR),
    .INIT_DATA(INIT_DATA), .INIT_VALID(INIT_VALID), .SIZE_LOG2(SIZE_LOG2),
    .CKSUM(CKSUM), .BYTE_CNT(BYTE_CNT), .READY(READY), .A(A), .CSB(CSB),
    .RAM_CSB(RAM_CSB), .WRB(WRB), .DI(DI), .DB(DB)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_underflow: observed 0x%0h with no expectation queued", obs);
    end else begin
      check_val(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  function automatic logic [7:0] byte_of(input int kind, input int i);
    case (kind)
      0:       return i[7:0];
      1:       return 8'h01;
      2:       return 8'(i * 7 + 3);
      default: return 8'hA5;
    endcase
  endfunction

  // Entered and left on a falling edge; covers the commit at m and m+1.
  task automatic load_image(input string tag, input int n, input int kind);
    logic [31:0] sum;
    int          mx;
    int          s;
    logic [7:0]  d;
    sum = 0;
    mx  = 0;
    for (int i = 0; i < n; i++) begin
      d          = byte_of(kind, i);
      INIT_SEL   = 1'b1;
      INIT_VALID = 1'b1;
      INIT_ADDR  = i[AW-1:0];
      INIT_DATA  = d;
      mdl[i]     = d;
      sum        = sum + {24'b0, d};
      mx         = i;
      @(negedge CLK);
    end
    if (n == 0) begin
      INIT_SEL   = 1'b1;
      INIT_VALID = 1'b0;
      repeat (5) @(negedge CLK);
    end
    s = 0;
    if (n != 0) begin
      while ((64'd1 << s) <= 64'(mx)) s++;
      if (s < 13) s = 13;
    end
    push_exp({tag, "_ready_m"}, 32'd0);
    push_exp({tag, "_size"},    32'(s));
    push_exp({tag, "_cksum"},   sum);
    push_exp({tag, "_cnt"},     32'(n));
    push_exp({tag, "_ready"},   32'(n != 0));
    INIT_SEL   = 1'b0;
    INIT_VALID = 1'b0;
    @(negedge CLK);
    pop_cmp(32'(READY));
    @(negedge CLK);
    pop_cmp(32'(SIZE_LOG2));
    pop_cmp(CKSUM);
    pop_cmp(32'(BYTE_CNT));
    pop_cmp(32'(READY));
  endtask

  task automatic cpu_access(input string tag, input logic [AW-1:0] a, input logic csb,
                            input logic rcsb, input logic wrb, input logic [7:0] di,
                            input logic [7:0] exp, input bit chk);
    A       = a;
    CSB     = csb;
    RAM_CSB = rcsb;
    WRB     = wrb;
    DI      = di;
    if (chk) push_exp(tag, 32'(exp));
    @(negedge CLK);
    if (chk) pop_cmp(32'(DB));
    CSB     = 1'b1;
    RAM_CSB = 1'b1;
    WRB     = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    push_exp({tag, "_size"},  32'd0);
    push_exp({tag, "_cksum"}, 32'd0);
    push_exp({tag, "_cnt"},   32'd0);
    push_exp({tag, "_ready"}, 32'd0);
    push_exp({tag, "_db"},    32'd0);
    pop_cmp(32'(SIZE_LOG2));
    pop_cmp(CKSUM);
    pop_cmp(32'(BYTE_CNT));
    pop_cmp(32'(READY));
    pop_cmp(32'(DB));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESB = 1'b0; INIT_SEL = 1'b0; INIT_VALID = 1'b0; INIT_ADDR = '0; INIT_DATA = '0;
    A = '0; CSB = 1'b1; RAM_CSB = 1'b1; WRB = 1'b1; DI = '0;
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    RESB = 1'b1;
    @(negedge CLK);

    cpu_access("rom_not_ready", 17'h00005, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b1);

    load_image("img8k", 8192, 0);
    cpu_access("rom_5",       17'h00005, 1'b0, 1'b1, 1'b1, 8'h00, mdl[5], 1'b1);
    cpu_access("rom_mirror8", 17'h12005, 1'b0, 1'b1, 1'b1, 8'h00, mdl[5], 1'b1);
    cpu_access("rom_top",     17'h01FFF, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF,  1'b1);
    cpu_access("db_hold",     17'h00000, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF,  1'b1);

    load_image("img_mir", 32'h2001, 2);
    cpu_access("rom_4005",  17'h04005, 1'b0, 1'b1, 1'b1, 8'h00, mdl[5],      1'b1);
    cpu_access("rom_2000",  17'h02000, 1'b0, 1'b1, 1'b1, 8'h00, mdl[32'h2000], 1'b1);
    cpu_access("rom_1e000", 17'h1E000, 1'b0, 1'b1, 1'b1, 8'h00, mdl[32'h2000], 1'b1);

    load_image("img_min", 16, 1);
    cpu_access("rom_min_2003", 17'h02003, 1'b0, 1'b1, 1'b1, 8'h00, mdl[3],     1'b1);
    cpu_access("rom_min_12",   17'h00012, 1'b0, 1'b1, 1'b1, 8'h00, mdl[32'h12], 1'b1);

    cpu_access("ram_prime",    17'h007FF, 1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 1'b0);
    cpu_access("ram_rbw",      17'h007FF, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h33, 1'b1);
    cpu_access("ram_read",     17'h007FF, 1'b1, 1'b0, 1'b1, 8'h00, 8'h5A, 1'b1);
    cpu_access("both_sel_rom", 17'h007FF, 1'b0, 1'b0, 1'b0, 8'h99, mdl[32'h7FF], 1'b1);
    cpu_access("ram_alias",    17'h00FFF, 1'b1, 1'b0, 1'b1, 8'h00, 8'h5A, 1'b1);

    load_image("img_empty", 0, 0);
    cpu_access("empty_rom_ff", 17'h00005, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b1);
    cpu_access("empty_ram_ff", 17'h007FF, 1'b1, 1'b0, 1'b0, 8'h11, 8'hFF, 1'b1);

    load_image("img_min2", 16, 1);
    cpu_access("ram_kept",  17'h007FF, 1'b1, 1'b0, 1'b1, 8'h00, 8'h5A, 1'b1);
    cpu_access("rom_min_8", 17'h00008, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 1'b1);

    for (int i = 0; i < 100; i++) begin
      INIT_SEL   = 1'b1;
      INIT_VALID = 1'b1;
      INIT_ADDR  = i[AW-1:0];
      INIT_DATA  = byte_of(3, i);
      mdl[i]     = byte_of(3, i);
      @(negedge CLK);
    end
    #2 RESB = 1'b0;
    #1 check_all_zero("async_rst");
    INIT_SEL   = 1'b0;
    INIT_VALID = 1'b0;
    @(negedge CLK);
    RESB = 1'b1;
    @(negedge CLK);

    load_image("img_after_rst", 8192, 0);
    cpu_access("rst_rom_2005", 17'h02005, 1'b0, 1'b1, 1'b1, 8'h00, 8'h05, 1'b1);
    cpu_access("rst_rom_10",   17'h00010, 1'b0, 1'b1, 1'b1, 8'h00, 8'h10, 1'b1);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d expectations never compared", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cart_mem.md
# cart_mem

Parametrised cartridge memory subsystem: the successor to the fixed 128K cartridge ROM, with configurable ROM address width and minimum image size. It loads a ROM image from the download port, then computes size, byte count and checksum through a small commit state machine. It serves CPU reads with power-of-two mirroring and adds optional battery-style cartridge RAM. It sits between the loader/download path and the SCV CPU bus decoder.

## Interface
- AW, 17: ROM address width; ROM depth is 2^AW bytes, with AW ≤ 31.
- MIN_LOG2, 13: smallest reported image size, as log2 of the byte count.
- RAM_AW, 11: cartridge RAM address width; 0 means no RAM is instantiated.

- CLK  in  1  system clock; all logic is rising-edge.
- RESB  in  1  reset; asynchronous, active-low.
- INIT_SEL  in  1  high while the loader streams the ROM image.
- INIT_ADDR  in  AW  byte address of the load data.
- INIT_DATA  in  8  load data byte.
- INIT_VALID  in  1  load strobe; honoured only while INIT_SEL is high.
- SIZE_LOG2  out  5  committed image size, as log2 of the byte count.
- CKSUM  out  32  committed sum of all loaded bytes, mod 2^32.
- BYTE_CNT  out  AW+1  committed count of INIT_VALID strobes.
- READY  out  1  image is committed and non-empty; CPU access is enabled.
- A  in  AW  CPU byte address.
- CSB  in  1  ROM select, active-low.
- RAM_CSB  in  1  RAM select, active-low; ignored when RAM_AW is 0.
- WRB  in  1  write strobe, active-low; applies to RAM only.
- DI  in  8  CPU write data.
- DB  out  8  registered read data.

## Operation
- **States:** IDLE, LOAD, COMMIT.
- **IDLE:**
  - Goes to LOAD whenever INIT_SEL is high. Detection is level-based, so a load request is never lost.
  - On entry to LOAD: READY goes to 0 and the accumulators are cleared.
- **LOAD, each cycle with INIT_VALID high:**
  - mem[INIT_ADDR] is written with INIT_DATA.
  - cksum += INIT_DATA, zero-extended, 32-bit wrap.
  - cnt += 1.
  - max_addr = max(max_addr, INIT_ADDR).
  - Any INIT_ADDR order is allowed; a repeated address overwrites memory and is counted and summed twice.
- **LOAD exit:** INIT_SEL low goes to COMMIT. INIT_VALID in that cycle is ignored.
- **COMMIT (one cycle):**
  - SIZE_LOG2 = max(MIN_LOG2, clog2(max_addr+1)).
  - CKSUM, BYTE_CNT and READY = (cnt != 0) are registered.
  - Then go to IDLE.
  - Empty load: SIZE_LOG2 = 0, CKSUM = 0, BYTE_CNT = 0, READY = 0.
- **ROM read:** with CSB low and READY high, DB is loaded from mem[A & ((1<<SIZE_LOG2)-1)]. Reads mirror across the whole 2^AW window.
- **RAM access:** applies with RAM_CSB low, CSB high and READY high.
  - DB is loaded from ram[A[RAM_AW-1:0]].
  - If WRB is low, ram is also written with DI. The read returns the old data (read-before-write).
- **Both selected:** ROM has priority and no RAM write occurs.
- **Not ready:** with CSB or RAM_CSB low and READY low (including during LOAD), DB is loaded with 8'hFF. No RAM write occurs.
- **Neither selected:** DB holds its value.
- **Reset:**
  - State goes to IDLE.
  - SIZE_LOG2, CKSUM, BYTE_CNT, READY and DB go to 0, along with the accumulators and max_addr.
  - ROM and RAM contents are not cleared.
- **Reset mid-LOAD:** the partial load is discarded. The next INIT_SEL high restarts the load from cleared accumulators.

## Timing
- **Read latency:** 1 cycle. A, CSB and RAM_CSB sampled at edge n give DB valid after edge n.
- **First byte:** the byte presented in the cycle where IDLE moves to LOAD is accepted, provided INIT_SEL and INIT_VALID are both high in that cycle. Clearing and accumulating happen on the same edge, so the first byte is not dropped.
- **Commit timing:**
  - INIT_SEL is first sampled low at edge m; the state moves LOAD to COMMIT.
  - At edge m+1, SIZE_LOG2, CKSUM, BYTE_CNT and READY update and the state moves to IDLE.
  - CPU access is honoured from edge m+2.
- **Quick re-load:** if INIT_SEL rises again during COMMIT, the commit still completes at m+1. LOAD is entered at m+2, and READY pulses high for one cycle if the completed load was non-empty.
- **Outputs between loads:** SIZE_LOG2, CKSUM and BYTE_CNT hold their last committed values through a subsequent LOAD until its own commit.
- **Write timing:** the RAM write takes effect at the edge where RAM_CSB and WRB are both sampled low. A read of the same address in the following cycle returns DI.

## Test plan
- **8K image:** after reset, load bytes 0x00..0xFF cycling over addresses 0x0000–0x1FFF.
  - Expect SIZE_LOG2 = 13, BYTE_CNT = 8192, CKSUM = 0x000FF000, READY = 1 at m+1.
- **Mirroring:** load 0x2001 bytes, so max_addr = 0x2000.
  - Expect SIZE_LOG2 = 14.
  - A read of A = 0x4005 returns the byte stored at 0x0005.
- **Minimum size:** load 16 bytes of 0x01.
  - Expect SIZE_LOG2 = 13, CKSUM = 16, BYTE_CNT = 16.
- **Empty load:** INIT_SEL high for 5 cycles with no INIT_VALID.
  - Expect SIZE_LOG2 = 0, CKSUM = 0, READY = 0.
  - A read with CSB low returns 0xFF.
- **Cartridge RAM:** write 0x5A to RAM address 0x7FF, then read it back.
  - Expect DB = 0x5A one cycle later, and old data returned during the write cycle.
  - With CSB and RAM_CSB both low and WRB low, the RAM is unchanged.
- **Reset mid-load:** drop RESB during LOAD after 100 bytes.
  - All outputs read 0 immediately (asynchronously).
  - A fresh 8K load commits correct values with no residue from the aborted load.
